// File: rtl/gnr_pkg.sv
// ============================================================================
//  Module      : gnr_pkg
//  Description : Shared types and constants for the GRN sweep controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gnr_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STEP   = 3'd2,
        CHECK  = 3'd3,
        PSTEP  = 3'd4,
        PCHECK = 3'd5,
        OUT    = 3'd6
    } gnr_state_e;

    localparam int GNR_N_NODES   = 8;
    localparam int GNR_SW        = 16;
    localparam int GNR_MAX_STEPS = 1024;

    // Result record: init + state (N_NODES each), steps + period (SW each), timeout flag.
    localparam int GNR_RES_FLAG_W = 1;

    function automatic int gnr_res_width(input int n_nodes, input int sw);
        return 2 * n_nodes + 2 * sw + GNR_RES_FLAG_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gnr_step_cnt.sv
// ============================================================================
//  Module      : gnr_step_cnt
//  Description : Saturating up-counter with clear and at-bound flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gnr_step_cnt
    import gnr_pkg::*;
#(
    parameter int SW        = GNR_SW,
    parameter int MAX_STEPS = GNR_MAX_STEPS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [SW-1:0] cnt_o,
    output logic          at_max_o
);

    localparam logic [SW-1:0] C_MAX = SW'(MAX_STEPS);

    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;

    // Clear wins over increment; increment stops at the bound.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q == C_MAX);

endmodule

`default_nettype wire

// File: rtl/gnr_attractor_ctrl.sv
// ============================================================================
//  Module      : gnr_attractor_ctrl
//  Description : Sweeps all initial states of the GRN array and finds each
//                attractor by tortoise/hare cycle detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int N_NODES   = GNR_N_NODES,
    parameter int SW        = GNR_SW,
    parameter int MAX_STEPS = GNR_MAX_STEPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [N_NODES-1:0] res_state,
    output logic [SW-1:0]      res_steps,
    output logic [SW-1:0]      res_period,
    output logic               res_timeout
);

    gnr_state_e         state_q,       state_d;
    logic [N_NODES-1:0] init_q,        init_d;
    logic               done_q,        done_d;
    logic [N_NODES-1:0] res_state_q,   res_state_d;
    logic [SW-1:0]      res_steps_q,   res_steps_d;
    logic [SW-1:0]      res_period_q,  res_period_d;
    logic               res_timeout_q, res_timeout_d;

    logic [SW-1:0]      step_cnt;
    logic               step_at_max;
    logic [SW-1:0]      period_cnt;
    logic               period_at_max;
    logic               meet;

    // The first joint step always compares equal vectors, so it never counts as a meet.
    assign meet = (step_cnt >= SW'(2)) && (s0_vec == s1_vec);

    gnr_step_cnt #(
        .SW        (SW),
        .MAX_STEPS (MAX_STEPS)
    ) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == LOAD),
        .inc_i    (state_q == STEP),
        .cnt_o    (step_cnt),
        .at_max_o (step_at_max)
    );

    gnr_step_cnt #(
        .SW        (SW),
        .MAX_STEPS (MAX_STEPS)
    ) u_period_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    ((state_q == CHECK) && meet),
        .inc_i    (state_q == PSTEP),
        .cnt_o    (period_cnt),
        .at_max_o (period_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            init_q        <= '0;
            done_q        <= 1'b0;
            res_state_q   <= '0;
            res_steps_q   <= '0;
            res_period_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_q        <= init_d;
            done_q        <= done_d;
            res_state_q   <= res_state_d;
            res_steps_q   <= res_steps_d;
            res_period_q  <= res_period_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_d        = init_q;
        done_d        = 1'b0;
        res_state_d   = res_state_q;
        res_steps_d   = res_steps_q;
        res_period_d  = res_period_q;
        res_timeout_d = res_timeout_q;
        unique case (state_q)
            IDLE: begin
                // done_q marks the done cycle, in which a new start is not accepted.
                if (start && !done_q) begin
                    state_d = LOAD;
                    init_d  = '0;
                end
            end
            LOAD: begin
                state_d = STEP;
            end
            STEP: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (meet) begin
                    res_state_d   = s0_vec;
                    res_steps_d   = step_cnt;
                    res_period_d  = '0;
                    res_timeout_d = 1'b0;
                    state_d       = PSTEP;
                end else if (step_at_max) begin
                    res_state_d   = s0_vec;
                    res_steps_d   = step_cnt;
                    res_period_d  = '0;
                    res_timeout_d = 1'b1;
                    state_d       = OUT;
                end else begin
                    state_d = STEP;
                end
            end
            PSTEP: begin
                state_d = PCHECK;
            end
            PCHECK: begin
                if (s1_vec == res_state_q) begin
                    res_period_d  = period_cnt;
                    res_timeout_d = 1'b0;
                    state_d       = OUT;
                end else if (period_at_max) begin
                    res_period_d  = '0;
                    res_timeout_d = 1'b1;
                    state_d       = OUT;
                end else begin
                    state_d = PSTEP;
                end
            end
            OUT: begin
                if (res_ready) begin
                    if (init_q == '1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        init_d  = init_q + N_NODES'(1);
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        reset_nos  = (state_q == LOAD);
        start_s0   = (state_q == STEP);
        start_s1   = (state_q == STEP) || (state_q == PSTEP);
        init_state = (state_q == LOAD) ? init_q : '0;
        res_valid  = (state_q == OUT);
    end

    assign done        = done_q;
    assign res_init    = init_q;
    assign res_state   = res_state_q;
    assign res_steps   = res_steps_q;
    assign res_period  = res_period_q;
    assign res_timeout = res_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_gnr_attractor_ctrl.sv
// ============================================================================
//  Module      : tb_gnr_attractor_ctrl
//  Description : Bench for gnr_attractor_ctrl with a 3-node network model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gnr_attractor_ctrl;

    typedef struct {
        logic [2:0] init;
        logic [2:0] state;
        int         steps;
        int         period;
        bit         to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;
    bit   sel  = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];

    logic start0 = 1'b0, start1 = 1'b0, rdy0 = 1'b0, rdy1 = 1'b0;

    logic        busy0, done0, rn0, ss00, ss10, rv0, rto0;
    logic [2:0]  init0, rinit0, rstate0;
    logic [2:0]  s0v0 = 3'd0, s1v0 = 3'd0;
    logic        ph0 = 1'b0;
    logic [15:0] rsteps0, rper0;

    logic        busy1, done1, rn1, ss01, ss11, rv1, rto1;
    logic [2:0]  init1, rinit1, rstate1;
    logic [2:0]  s0v1 = 3'd0, s1v1 = 3'd0;
    logic        ph1 = 1'b0;
    logic [15:0] rsteps1, rper1;

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.N_NODES(3), .SW(16), .MAX_STEPS(1024)) dut (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .reset_nos(rn0), .start_s0(ss00), .start_s1(ss10), .init_state(init0),
        .s0_vec(s0v0), .s1_vec(s1v0), .res_valid(rv0), .res_ready(rdy0),
        .res_init(rinit0), .res_state(rstate0), .res_steps(rsteps0),
        .res_period(rper0), .res_timeout(rto0)
    );

    gnr_attractor_ctrl #(.N_NODES(3), .SW(16), .MAX_STEPS(4)) dut_t (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .reset_nos(rn1), .start_s0(ss01), .start_s1(ss11), .init_state(init1),
        .s0_vec(s0v1), .s1_vec(s1v1), .res_valid(rv1), .res_ready(rdy1),
        .res_init(rinit1), .res_state(rstate1), .res_steps(rsteps1),
        .res_period(rper1), .res_timeout(rto1)
    );

    // Network next-state: mode 0 identity, mode 1 rotate-left.
    function automatic logic [2:0] nxt(input int md, input logic [2:0] x);
        return (md == 0) ? x : {x[1:0], x[2]};
    endfunction

    // Node cells: s0 advances on odd-numbered start_s0 pulses after a load.
    always @(posedge clk) begin
        if (rn0) begin
            s0v0 <= init0; s1v0 <= init0; ph0 <= 1'b0;
        end else begin
            if (ss00) begin
                if (!ph0) s0v0 <= nxt(mode, s0v0);
                ph0 <= ~ph0;
            end
            if (ss10) s1v0 <= nxt(mode, s1v0);
        end
    end

    always @(posedge clk) begin
        if (rn1) begin
            s0v1 <= init1; s1v1 <= init1; ph1 <= 1'b0;
        end else begin
            if (ss01) begin
                if (!ph1) s0v1 <= nxt(mode, s0v1);
                ph1 <= ~ph1;
            end
            if (ss11) s1v1 <= nxt(mode, s1v1);
        end
    end

    logic        v_busy, v_done, v_rn, v_ss0, v_ss1, v_valid, v_rto;
    logic [2:0]  v_rinit, v_rstate;
    logic [15:0] v_rsteps, v_rper;
    assign v_busy   = sel ? busy1   : busy0;
    assign v_done   = sel ? done1   : done0;
    assign v_rn     = sel ? rn1     : rn0;
    assign v_ss0    = sel ? ss01    : ss00;
    assign v_ss1    = sel ? ss11    : ss10;
    assign v_valid  = sel ? rv1     : rv0;
    assign v_rto    = sel ? rto1    : rto0;
    assign v_rinit  = sel ? rinit1  : rinit0;
    assign v_rstate = sel ? rstate1 : rstate0;
    assign v_rsteps = sel ? rsteps1 : rsteps0;
    assign v_rper   = sel ? rper1   : rper0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv_start(input logic b);
        if (sel) start1 = b; else start0 = b;
    endtask

    task automatic drv_ready(input logic b);
        if (sel) rdy1 = b; else rdy0 = b;
    endtask

    // Abstract reference: tortoise/hare over the network function.
    function automatic exp_t ref_rec(input int md, input logic [2:0] init, input int maxs);
        exp_t e;
        logic [2:0] a, b;
        bit found;
        e.init = init; e.state = init; e.steps = 0; e.period = 0; e.to = 1'b0;
        a = init; b = init; found = 1'b0;
        for (int k = 1; k <= maxs && !found; k++) begin
            b = nxt(md, b);
            if (k % 2 == 1) a = nxt(md, a);
            e.steps = k;
            if (k >= 2 && a == b) begin
                found = 1'b1; e.state = a;
            end
        end
        if (!found) begin
            e.to = 1'b1;
            return e;
        end
        found = 1'b0;
        for (int k = 1; k <= maxs && !found; k++) begin
            b = nxt(md, b);
            if (b == e.state) begin
                found = 1'b1; e.period = k;
            end
        end
        if (!found) e.to = 1'b1;
        return e;
    endfunction

    task automatic compare_rec(input int maxs);
        exp_t e;
        if (q.size() == 0) begin
            chk("extra_result", 1, 0);
            return;
        end
        e = q.pop_front();
        chk("res_init",    v_rinit,  e.init);
        chk("res_steps",   v_rsteps, e.steps);
        chk("res_period",  v_rper,   e.period);
        chk("res_timeout", v_rto,    e.to);
        if (!e.to) chk("res_state", v_rstate, e.state);
        if (mode == 0) begin
            chk("ident_steps", v_rsteps, 2);
            chk("ident_state", v_rstate, v_rinit);
        end else if (maxs == 1024 && e.init == 3'b001) begin
            chk("rot1_steps", v_rsteps, 6);
            chk("rot1_period", v_rper, 3);
            chk("rot1_state", v_rstate, 3'b001);
        end else if (maxs == 1024 && e.init == 3'b000) begin
            chk("rot0_steps", v_rsteps, 2);
            chk("rot0_period", v_rper, 1);
        end else if (maxs == 4 && e.init == 3'b001) begin
            chk("tmo_flag", v_rto, 1);
            chk("tmo_period", v_rper, 0);
            chk("tmo_steps", v_rsteps, 4);
        end
    endtask

    task automatic run_sweep(input int md, input int stall_idx, input bit spam);
        int idx, maxs;
        bit fin, load_chk;
        logic [38:0] snap;
        idx = 0; fin = 1'b0; load_chk = 1'b0;
        mode = md;
        maxs = sel ? 4 : 1024;
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(ref_rec(md, 3'(i), maxs));
        @(negedge clk); drv_start(1'b1);
        @(negedge clk); drv_start(1'b0);
        chk("busy_after_start", v_busy, 1);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            drv_ready(1'b0);
            drv_start(1'b0);
            if (load_chk) begin
                chk("load_after_accept", v_rn, 1);
                load_chk = 1'b0;
            end
            if (v_done) begin
                chk("busy_at_done", v_busy, 0);
                fin = 1'b1;
            end else if (v_valid) begin
                if (idx == stall_idx) begin
                    snap = {v_rinit, v_rstate, v_rsteps, v_rper, v_rto};
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        chk("stall_hold",
                            {v_valid, v_rn, v_ss0, v_ss1, v_rinit, v_rstate, v_rsteps, v_rper, v_rto},
                            {4'b1000, snap});
                    end
                    load_chk = 1'b1;
                end
                compare_rec(maxs);
                drv_ready(1'b1);
                idx++;
            end else if (spam && v_busy && (cyc % 5 == 0)) begin
                drv_start(1'b1);
            end
        end
        chk("sweep_finished", fin, 1);
        chk("result_count", idx, 8);
        chk("queue_left", q.size(), 0);
        if (fin) begin
            if (spam) drv_start(1'b1);
            @(negedge clk);
            drv_start(1'b0);
            chk("done_single", v_done, 0);
            chk("idle_after_done", {v_busy, v_rn, v_valid}, 0);
        end
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {busy0, done0, rn0, ss00, ss10, init0, rv0, rinit0, rstate0, rsteps0, rper0, rto0}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {busy0, done0, rn0, rv0}, 0);

        run_sweep(0, -1, 1'b0);
        run_sweep(1, 2, 1'b1);
        sel = 1'b1;
        run_sweep(1, -1, 1'b0);
        sel = 1'b0;

        // Abort a sweep with reset while the period search is running.
        mode = 1;
        found = 1'b0;
        @(negedge clk); drv_start(1'b1);
        @(negedge clk); drv_start(1'b0);
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            @(negedge clk);
            if (v_ss1 && !v_ss0) found = 1'b1;
        end
        chk("found_pstep", found, 1);
        if (found) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rst_mid_pstep",
                {busy0, done0, rn0, ss00, ss10, init0, rv0, rinit0, rstate0, rsteps0, rper0, rto0}, 0);
            rst = 1'b0;
            @(negedge clk);
            chk("no_done_after_abort", {busy0, done0}, 0);
        end
        run_sweep(0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
